// File: rtl/line_buf_addr_gen_pkg.sv
// Shared defaults and helpers for the median filter's line-buffer address generator.
package line_buf_pkg;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    // A single-entry index still needs one bit to be a legal vector.
    return (r < 1) ? 1 : r;
  endfunction

  localparam int DEF_MAX_PIX   = 1920;
  localparam int DEF_NUM_LINES = 3;
  localparam int DEF_ADDR_W    = 11;
  localparam int DEF_LINE_W    = clog2(DEF_NUM_LINES);

endpackage

// File: rtl/line_buf_addr_gen_if.sv
// Video-timing inputs and line-RAM write/status outputs of the line-buffer address generator.
interface line_buf_addr_gen_if
  import line_buf_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int NUM_LINES = DEF_NUM_LINES,
  parameter int LINE_W    = clog2(NUM_LINES)
);

  logic                 hsync;
  logic                 vsync;
  logic                 de;
  logic [ADDR_W-1:0]    wr_addr;
  logic                 wr_en;
  logic [LINE_W-1:0]    wr_line;
  logic [NUM_LINES-1:0] wr_sel;
  logic [ADDR_W-1:0]    line_len;
  logic [LINE_W-1:0]    lines_filled;
  logic                 window_valid;
  logic                 overflow;

  // Video source / downstream datapath side.
  modport master (
    output hsync, vsync, de,
    input  wr_addr, wr_en, wr_line, wr_sel, line_len, lines_filled, window_valid, overflow
  );

  // Address generator side.
  modport slave (
    input  hsync, vsync, de,
    output wr_addr, wr_en, wr_line, wr_sel, line_len, lines_filled, window_valid, overflow
  );

endinterface

// File: rtl/line_buf_addr_gen_sync_edge_det.sv
// Normalises a sync input to active-high and flags its leading edge in the same cycle.
module sync_edge_det #(
  parameter bit POL     = 1'b1,
  parameter bit RST_LVL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic sync_in,
  output logic lvl,
  output logic edge_p
);

  logic lvl_d;

  assign lvl    = (sync_in == POL);
  assign edge_p = lvl & ~lvl_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) lvl_d <= RST_LVL;
    else     lvl_d <= lvl;
  end

endmodule

// File: rtl/line_buf_addr_gen.sv
// Pixel write-address counter and line-RAM rotation for the median filter's multi-line buffer.
module line_buf_addr_gen
  import line_buf_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int MAX_PIX   = DEF_MAX_PIX,
  parameter int NUM_LINES = DEF_NUM_LINES,
  parameter int LINE_W    = clog2(NUM_LINES),
  parameter bit SYNC_POL  = 1'b1
) (
  input logic                clk,
  input logic                rst,
  line_buf_addr_gen_if.slave bus
);

  localparam logic [ADDR_W-1:0]    MAX_ADDR  = ADDR_W'(MAX_PIX);
  localparam logic [LINE_W-1:0]    LAST_LINE = LINE_W'(NUM_LINES - 1);
  localparam logic [NUM_LINES-1:0] SEL_RST   = NUM_LINES'(1);

  logic                 hs_a, vs_a;
  logic                 h_edge, v_edge;
  logic                 pix_room;
  logic [ADDR_W-1:0]    addr_q;
  logic [LINE_W-1:0]    line_q;
  logic [NUM_LINES-1:0] sel_q;
  logic [ADDR_W-1:0]    len_q;
  logic [LINE_W-1:0]    filled_q;
  logic                 ovf_q;

  // Delayed syncs reset to the active level so a sync held through reset is not an edge.
  sync_edge_det #(.POL(SYNC_POL), .RST_LVL(1'b1)) u_hs_det (
    .clk(clk), .rst(rst), .sync_in(bus.hsync), .lvl(hs_a), .edge_p(h_edge)
  );

  sync_edge_det #(.POL(SYNC_POL), .RST_LVL(1'b1)) u_vs_det (
    .clk(clk), .rst(rst), .sync_in(bus.vsync), .lvl(vs_a), .edge_p(v_edge)
  );

  // Normalised levels are available for future consumers; only the edges drive state today.
  logic unused_sync_lvl;
  assign unused_sync_lvl = hs_a ^ vs_a;

  assign pix_room = (addr_q < MAX_ADDR);
  assign bus.wr_en = bus.de & ~h_edge & ~v_edge & pix_room & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      line_q   <= '0;
      sel_q    <= SEL_RST;
      len_q    <= '0;
      filled_q <= '0;
      ovf_q    <= 1'b0;
    end else if (v_edge) begin
      // Frame restart absorbs any coincident hsync edge; line_len survives across frames.
      addr_q   <= '0;
      line_q   <= '0;
      sel_q    <= SEL_RST;
      filled_q <= '0;
      ovf_q    <= 1'b0;
    end else if (h_edge) begin
      addr_q <= '0;
      if (addr_q != '0) begin
        len_q  <= addr_q;
        line_q <= (line_q == LAST_LINE) ? '0 : line_q + 1'b1;
        sel_q  <= {sel_q[NUM_LINES-2:0], sel_q[NUM_LINES-1]};
        if (filled_q != LAST_LINE) filled_q <= filled_q + 1'b1;
      end
    end else if (bus.de) begin
      if (pix_room) addr_q <= addr_q + 1'b1;
      else          ovf_q  <= 1'b1;
    end
  end

  assign bus.wr_addr      = addr_q;
  assign bus.wr_line      = line_q;
  assign bus.wr_sel       = sel_q;
  assign bus.line_len     = len_q;
  assign bus.lines_filled = filled_q;
  assign bus.window_valid = (filled_q == LAST_LINE);
  assign bus.overflow     = ovf_q;

endmodule

// File: tb/tb_line_buf_addr_gen.sv
// Bench for line_buf_addr_gen: an active-high and an active-low sync instance share one reference model.
module tb_line_buf_addr_gen;

  localparam int ADDR_W    = 4;
  localparam int MAX_PIX   = 8;
  localparam int NUM_LINES = 3;
  localparam int LINE_W    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  line_buf_addr_gen_if #(.ADDR_W(ADDR_W), .NUM_LINES(NUM_LINES), .LINE_W(LINE_W)) bus_p ();
  line_buf_addr_gen_if #(.ADDR_W(ADDR_W), .NUM_LINES(NUM_LINES), .LINE_W(LINE_W)) bus_n ();

  line_buf_addr_gen #(.ADDR_W(ADDR_W), .MAX_PIX(MAX_PIX), .NUM_LINES(NUM_LINES),
                      .LINE_W(LINE_W), .SYNC_POL(1'b1)) u_dut_p (.clk(clk), .rst(rst), .bus(bus_p));
  line_buf_addr_gen #(.ADDR_W(ADDR_W), .MAX_PIX(MAX_PIX), .NUM_LINES(NUM_LINES),
                      .LINE_W(LINE_W), .SYNC_POL(1'b0)) u_dut_n (.clk(clk), .rst(rst), .bus(bus_n));

  // Index 0 = active-high sync instance, 1 = active-low sync instance.
  logic [ADDR_W-1:0]    o_addr [2];
  logic [ADDR_W-1:0]    o_len [2];
  logic [LINE_W-1:0]    o_line [2];
  logic [LINE_W-1:0]    o_filled [2];
  logic [NUM_LINES-1:0] o_sel [2];
  logic                 o_en [2];
  logic                 o_wv [2];
  logic                 o_ovf [2];

  assign o_addr[0] = bus_p.wr_addr;      assign o_addr[1] = bus_n.wr_addr;
  assign o_len[0] = bus_p.line_len;      assign o_len[1] = bus_n.line_len;
  assign o_line[0] = bus_p.wr_line;      assign o_line[1] = bus_n.wr_line;
  assign o_filled[0] = bus_p.lines_filled; assign o_filled[1] = bus_n.lines_filled;
  assign o_sel[0] = bus_p.wr_sel;        assign o_sel[1] = bus_n.wr_sel;
  assign o_en[0] = bus_p.wr_en;          assign o_en[1] = bus_n.wr_en;
  assign o_wv[0] = bus_p.window_valid;   assign o_wv[1] = bus_n.window_valid;
  assign o_ovf[0] = bus_p.overflow;      assign o_ovf[1] = bus_n.overflow;

  int checks = 0;
  int errors = 0;

  // Reference model: logical (active-high) sync levels and per-frame line bookkeeping.
  bit in_hs = 1'b0, in_vs = 1'b0, in_de = 1'b0;
  bit m_phs = 1'b1, m_pvs = 1'b1;
  int m_pix = 0, m_line = 0, m_filled = 0, m_len = 0;
  bit m_ovf = 1'b0;

  function automatic bit exp_en();
    return in_de && !(in_hs && !m_phs) && !(in_vs && !m_pvs) && (m_pix < MAX_PIX) && !rst;
  endfunction

  task automatic apply(input bit hs, input bit vs, input bit de);
    in_hs = hs; in_vs = vs; in_de = de;
    bus_p.hsync = hs;  bus_p.vsync = vs;  bus_p.de = de;
    bus_n.hsync = ~hs; bus_n.vsync = ~vs; bus_n.de = de;
    #1;
  endtask

  task automatic advance();
    bit he, ve;
    he = in_hs && !m_phs;
    ve = in_vs && !m_pvs;
    if (rst) begin
      m_pix = 0; m_line = 0; m_filled = 0; m_len = 0; m_ovf = 1'b0;
      m_phs = 1'b1; m_pvs = 1'b1;
    end else begin
      if (ve) begin
        m_pix = 0; m_line = 0; m_filled = 0; m_ovf = 1'b0;
      end else if (he) begin
        if (m_pix > 0) begin
          m_len    = m_pix;
          m_line   = (m_line + 1) % NUM_LINES;
          m_filled = (m_filled + 1 > NUM_LINES - 1) ? NUM_LINES - 1 : m_filled + 1;
        end
        m_pix = 0;
      end else if (in_de) begin
        if (m_pix < MAX_PIX) m_pix++;
        else                 m_ovf = 1'b1;
      end
      m_phs = in_hs; m_pvs = in_vs;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_line(input int n);
    for (int i = 0; i < n; i++) begin apply(0, 0, 1); advance(); end
    apply(1, 0, 0); advance();
    apply(0, 0, 0); advance();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    apply(0, 0, 1); advance();
    apply(0, 0, 1);
    for (int d = 0; d < 2; d++) begin
      checks++; if (o_en[d] !== 1'b0) begin errors++; $display("FAIL reset_wr_en dut%0d: got %0b expected 0", d, o_en[d]); end
    end
    advance();
    for (int d = 0; d < 2; d++) begin
      checks++; if (o_addr[d] !== 4'd0) begin errors++; $display("FAIL reset_wr_addr dut%0d: got %0d expected 0", d, o_addr[d]); end
      checks++; if (o_line[d] !== 2'd0) begin errors++; $display("FAIL reset_wr_line dut%0d: got %0d expected 0", d, o_line[d]); end
      checks++; if (o_sel[d] !== 3'b001) begin errors++; $display("FAIL reset_wr_sel dut%0d: got %b expected 001", d, o_sel[d]); end
      checks++; if (o_len[d] !== 4'd0) begin errors++; $display("FAIL reset_line_len dut%0d: got %0d expected 0", d, o_len[d]); end
      checks++; if (o_filled[d] !== 2'd0) begin errors++; $display("FAIL reset_lines_filled dut%0d: got %0d expected 0", d, o_filled[d]); end
      checks++; if (o_wv[d] !== 1'b0) begin errors++; $display("FAIL reset_window_valid dut%0d: got %0b expected 0", d, o_wv[d]); end
      checks++; if (o_ovf[d] !== 1'b0) begin errors++; $display("FAIL reset_overflow dut%0d: got %0b expected 0", d, o_ovf[d]); end
    end
  endtask

  task automatic test_first_line();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      apply(0, 0, 1);
      for (int d = 0; d < 2; d++) begin
        checks++; if (o_en[d] !== 1'b1) begin errors++; $display("FAIL first_wr_en dut%0d pix%0d: got %0b expected 1", d, i, o_en[d]); end
        checks++; if (o_addr[d] !== 4'(i)) begin errors++; $display("FAIL first_wr_addr dut%0d: got %0d expected %0d", d, o_addr[d], i); end
      end
      advance();
    end
    apply(1, 0, 1);
    for (int d = 0; d < 2; d++) begin
      checks++; if (o_en[d] !== 1'b0) begin errors++; $display("FAIL hedge_drops_de dut%0d: got %0b expected 0", d, o_en[d]); end
    end
    advance();
    apply(0, 0, 0);
    for (int d = 0; d < 2; d++) begin
      checks++; if (o_addr[d] !== 4'd0) begin errors++; $display("FAIL first_addr_clr dut%0d: got %0d expected 0", d, o_addr[d]); end
      checks++; if (o_len[d] !== 4'd5) begin errors++; $display("FAIL first_line_len dut%0d: got %0d expected 5", d, o_len[d]); end
      checks++; if (o_line[d] !== 2'd1) begin errors++; $display("FAIL first_wr_line dut%0d: got %0d expected 1", d, o_line[d]); end
      checks++; if (o_sel[d] !== 3'b010) begin errors++; $display("FAIL first_wr_sel dut%0d: got %b expected 010", d, o_sel[d]); end
      checks++; if (o_filled[d] !== 2'd1) begin errors++; $display("FAIL first_filled dut%0d: got %0d expected 1", d, o_filled[d]); end
      checks++; if (o_wv[d] !== 1'b0) begin errors++; $display("FAIL first_window_valid dut%0d: got %0b expected 0", d, o_wv[d]); end
    end
    advance();
  endtask

  task automatic test_rotation();
    int exp_line [3] = '{2, 0, 1};
    bit [2:0] exp_sel [3] = '{3'b100, 3'b001, 3'b010};
    for (int k = 0; k < 3; k++) begin
      send_line(4);
      for (int d = 0; d < 2; d++) begin
        checks++; if (o_line[d] !== 2'(exp_line[k])) begin errors++; $display("FAIL rot_wr_line dut%0d line%0d: got %0d expected %0d", d, k, o_line[d], exp_line[k]); end
        checks++; if (o_sel[d] !== exp_sel[k]) begin errors++; $display("FAIL rot_wr_sel dut%0d line%0d: got %b expected %b", d, k, o_sel[d], exp_sel[k]); end
        checks++; if (o_filled[d] !== 2'd2) begin errors++; $display("FAIL rot_filled dut%0d line%0d: got %0d expected 2", d, k, o_filled[d]); end
        checks++; if (o_wv[d] !== 1'b1) begin errors++; $display("FAIL rot_window_valid dut%0d line%0d: got %0b expected 1", d, k, o_wv[d]); end
        checks++; if (o_len[d] !== 4'd4) begin errors++; $display("FAIL rot_line_len dut%0d line%0d: got %0d expected 4", d, k, o_len[d]); end
      end
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 10; i++) begin
      apply(0, 0, 1);
      for (int d = 0; d < 2; d++) begin
        checks++; if (o_en[d] !== (i < MAX_PIX)) begin errors++; $display("FAIL ovf_wr_en dut%0d pix%0d: got %0b expected %0b", d, i, o_en[d], (i < MAX_PIX)); end
        checks++; if (o_addr[d] !== 4'((i < MAX_PIX) ? i : MAX_PIX)) begin errors++; $display("FAIL ovf_wr_addr dut%0d pix%0d: got %0d", d, i, o_addr[d]); end
      end
      advance();
    end
    apply(1, 0, 0); advance();
    apply(0, 0, 0); advance();
    for (int d = 0; d < 2; d++) begin
      checks++; if (o_ovf[d] !== 1'b1) begin errors++; $display("FAIL ovf_sticky dut%0d: got %0b expected 1", d, o_ovf[d]); end
      checks++; if (o_len[d] !== 4'd8) begin errors++; $display("FAIL ovf_line_len dut%0d: got %0d expected 8", d, o_len[d]); end
      checks++; if (o_line[d] !== 2'd2) begin errors++; $display("FAIL ovf_wr_line dut%0d: got %0d expected 2", d, o_line[d]); end
    end
    apply(0, 1, 0); advance();
    apply(0, 0, 0); advance();
    for (int d = 0; d < 2; d++) begin
      checks++; if (o_ovf[d] !== 1'b0) begin errors++; $display("FAIL vsync_clr_ovf dut%0d: got %0b expected 0", d, o_ovf[d]); end
      checks++; if (o_line[d] !== 2'd0) begin errors++; $display("FAIL vsync_wr_line dut%0d: got %0d expected 0", d, o_line[d]); end
      checks++; if (o_sel[d] !== 3'b001) begin errors++; $display("FAIL vsync_wr_sel dut%0d: got %b expected 001", d, o_sel[d]); end
      checks++; if (o_filled[d] !== 2'd0) begin errors++; $display("FAIL vsync_filled dut%0d: got %0d expected 0", d, o_filled[d]); end
      checks++; if (o_len[d] !== 4'd8) begin errors++; $display("FAIL vsync_keeps_len dut%0d: got %0d expected 8", d, o_len[d]); end
    end
  endtask

  task automatic test_blank_line();
    apply(1, 0, 0); advance();
    apply(0, 0, 0); advance();
    for (int d = 0; d < 2; d++) begin
      checks++; if (o_line[d] !== 2'd0) begin errors++; $display("FAIL blank_wr_line dut%0d: got %0d expected 0", d, o_line[d]); end
      checks++; if (o_len[d] !== 4'd8) begin errors++; $display("FAIL blank_line_len dut%0d: got %0d expected 8", d, o_len[d]); end
      checks++; if (o_filled[d] !== 2'd0) begin errors++; $display("FAIL blank_filled dut%0d: got %0d expected 0", d, o_filled[d]); end
    end
    send_line(3);
    apply(1, 0, 0); advance();
    apply(0, 0, 0); advance();
    for (int d = 0; d < 2; d++) begin
      checks++; if (o_line[d] !== 2'd1) begin errors++; $display("FAIL blank2_wr_line dut%0d: got %0d expected 1", d, o_line[d]); end
      checks++; if (o_len[d] !== 4'd3) begin errors++; $display("FAIL blank2_line_len dut%0d: got %0d expected 3", d, o_len[d]); end
      checks++; if (o_filled[d] !== 2'd1) begin errors++; $display("FAIL blank2_filled dut%0d: got %0d expected 1", d, o_filled[d]); end
    end
  endtask

  task automatic test_coincident_edges();
    apply(0, 0, 1); advance();
    apply(0, 0, 1); advance();
    apply(1, 1, 1);
    for (int d = 0; d < 2; d++) begin
      checks++; if (o_en[d] !== 1'b0) begin errors++; $display("FAIL coin_wr_en dut%0d: got %0b expected 0", d, o_en[d]); end
    end
    advance();
    apply(0, 0, 0); advance();
    for (int d = 0; d < 2; d++) begin
      checks++; if (o_line[d] !== 2'd0) begin errors++; $display("FAIL coin_wr_line dut%0d: got %0d expected 0", d, o_line[d]); end
      checks++; if (o_filled[d] !== 2'd0) begin errors++; $display("FAIL coin_filled dut%0d: got %0d expected 0", d, o_filled[d]); end
      checks++; if (o_len[d] !== 4'd3) begin errors++; $display("FAIL coin_line_len dut%0d: got %0d expected 3", d, o_len[d]); end
      checks++; if (o_addr[d] !== 4'd0) begin errors++; $display("FAIL coin_wr_addr dut%0d: got %0d expected 0", d, o_addr[d]); end
    end
  endtask

  task automatic test_sync_held_through_reset();
    for (int i = 0; i < 3; i++) begin apply(0, 0, 1); advance(); end
    rst = 1'b1;
    apply(1, 0, 1);
    for (int d = 0; d < 2; d++) begin
      checks++; if (o_en[d] !== 1'b0) begin errors++; $display("FAIL rst_mid_wr_en dut%0d: got %0b expected 0", d, o_en[d]); end
    end
    advance();
    apply(1, 0, 1); advance();
    for (int d = 0; d < 2; d++) begin
      checks++; if (o_addr[d] !== 4'd0) begin errors++; $display("FAIL rst_mid_wr_addr dut%0d: got %0d expected 0", d, o_addr[d]); end
      checks++; if (o_len[d] !== 4'd0) begin errors++; $display("FAIL rst_mid_line_len dut%0d: got %0d expected 0", d, o_len[d]); end
    end
    rst = 1'b0;
    apply(1, 0, 1);
    for (int d = 0; d < 2; d++) begin
      checks++; if (o_en[d] !== 1'b1) begin errors++; $display("FAIL held_sync_wr_en dut%0d: got %0b expected 1", d, o_en[d]); end
    end
    advance();
    for (int d = 0; d < 2; d++) begin
      checks++; if (o_line[d] !== 2'd0) begin errors++; $display("FAIL held_sync_wr_line dut%0d: got %0d expected 0", d, o_line[d]); end
      checks++; if (o_addr[d] !== 4'd1) begin errors++; $display("FAIL held_sync_wr_addr dut%0d: got %0d expected 1", d, o_addr[d]); end
    end
    apply(0, 0, 1); advance();
    apply(1, 0, 0); advance();
    apply(0, 0, 0); advance();
    for (int d = 0; d < 2; d++) begin
      checks++; if (o_line[d] !== 2'd1) begin errors++; $display("FAIL held_next_wr_line dut%0d: got %0d expected 1", d, o_line[d]); end
      checks++; if (o_len[d] !== 4'd2) begin errors++; $display("FAIL held_next_line_len dut%0d: got %0d expected 2", d, o_len[d]); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      apply($urandom_range(0, 9) == 0, $urandom_range(0, 79) == 0, $urandom_range(0, 3) != 0);
      for (int d = 0; d < 2; d++) begin
        checks++; if (o_en[d] !== exp_en()) begin errors++; $display("FAIL rnd_wr_en dut%0d cyc%0d: got %0b expected %0b", d, c, o_en[d], exp_en()); end
        checks++; if (o_addr[d] !== 4'(m_pix)) begin errors++; $display("FAIL rnd_wr_addr dut%0d cyc%0d: got %0d expected %0d", d, c, o_addr[d], m_pix); end
        checks++; if (o_line[d] !== 2'(m_line)) begin errors++; $display("FAIL rnd_wr_line dut%0d cyc%0d: got %0d expected %0d", d, c, o_line[d], m_line); end
        checks++; if (o_sel[d] !== 3'(1 << m_line)) begin errors++; $display("FAIL rnd_wr_sel dut%0d cyc%0d: got %b expected %b", d, c, o_sel[d], 3'(1 << m_line)); end
        checks++; if (o_len[d] !== 4'(m_len)) begin errors++; $display("FAIL rnd_line_len dut%0d cyc%0d: got %0d expected %0d", d, c, o_len[d], m_len); end
        checks++; if (o_filled[d] !== 2'(m_filled)) begin errors++; $display("FAIL rnd_filled dut%0d cyc%0d: got %0d expected %0d", d, c, o_filled[d], m_filled); end
        checks++; if (o_wv[d] !== (m_filled == NUM_LINES - 1)) begin errors++; $display("FAIL rnd_window_valid dut%0d cyc%0d: got %0b", d, c, o_wv[d]); end
        checks++; if (o_ovf[d] !== m_ovf) begin errors++; $display("FAIL rnd_overflow dut%0d cyc%0d: got %0b expected %0b", d, c, o_ovf[d], m_ovf); end
      end
      advance();
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_line();
    test_rotation();
    test_overflow();
    test_blank_line();
    test_coincident_edges();
    test_sync_held_through_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
